// File: rtl/frame_pkg.sv
// Shared constants for the UDP frame header inserter (TX) and the RX header detector.
// Holds header geometry, default parameter values and the framer state encoding.
package frame_pkg;

  // Number of header bytes preceding every frame.
  localparam int unsigned HDR_LEN = 2;

  // Number of sequence-number bytes inserted after the header when sequencing is enabled.
  localparam int unsigned SEQ_LEN = 1;

  // Default value of each header byte; the RX detector keys on this pattern.
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h00;

  // Default upper bound on accepted payload length.
  localparam logic [15:0] MAX_PAYLOAD_DEFAULT = 16'd1470;

  // Framer state encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HDR0 = 3'd2,
    ST_HDR1 = 3'd3,
    ST_SEQ  = 3'd4,
    ST_PAY  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/frame_header_insert.sv
// UDP TX-side framer on udp_clk. Emits HDR_LEN header bytes, optionally a sequence byte,
// then streams payload_len bytes from a payload FIFO with one cycle of read latency.
// Handshakes with the UDP stack app TX port: request held until ack, data starts the
// cycle after ack and runs back-to-back without backpressure.
// Optional feature: define FRAME_SEQ_EN to insert an 8-bit wrapping frame sequence
// number after the header (frame length then grows by one byte).
module frame_header_insert
  import frame_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter logic [15:0] MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT
) (
  input  logic        udp_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] payload_len,
  output logic        pay_rd_en,
  input  logic [7:0]  pay_data,
  input  logic        udp_tx_ready,
  output logic        app_tx_data_request,
  input  logic        app_tx_ack,
  output logic [7:0]  app_tx_data,
  output logic        app_tx_data_valid,
  output logic [15:0] app_tx_data_length,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef FRAME_SEQ_EN
  localparam logic [15:0] OVERHEAD    = 16'(HDR_LEN + SEQ_LEN);
  // The sequence byte is the last byte before payload, so it issues the first FIFO read.
  localparam state_e      LAST_PRE_ST = ST_SEQ;
`else
  localparam logic [15:0] OVERHEAD    = 16'(HDR_LEN);
  localparam state_e      LAST_PRE_ST = ST_HDR1;
`endif

  state_e      state_q;
  logic [15:0] len_q;       // latched payload length for the current frame
  logic [15:0] rem_q;       // payload bytes remaining, including the one on the bus
  logic [15:0] rem_d;       // rem_q after the current payload byte
  logic [15:0] length_q;    // total frame length presented to the stack
  logic        req_q;
  logic        valid_q;
  logic [7:0]  data_q;      // header / sequence byte driven outside PAY
  logic        pay_sel_q;   // steer FIFO data onto the bus during PAY
  logic        rd_en_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
`ifdef FRAME_SEQ_EN
  logic [7:0]  seq_q;       // sequence number of the next frame to be sent
`endif

  assign rem_d = rem_q - 16'd1;

  // Frame sequencer: state, counters and all registered outputs advance together.
  // NOTE: sequential state uses non-blocking assignments so every register in this block
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge udp_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      length_q  <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      pay_sel_q <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef FRAME_SEQ_EN
      seq_q     <= '0;
`endif
    end else begin
      // done and err are single-cycle pulses unless re-armed below.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (payload_len > MAX_PAYLOAD) begin
              err_q <= 1'b1;
            end else if (udp_tx_ready) begin
              state_q  <= ST_REQ;
              len_q    <= payload_len;
              length_q <= payload_len + OVERHEAD;
              req_q    <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          if (app_tx_ack) begin
            state_q <= ST_HDR0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= HDR_BYTE;
          end
        end

        ST_HDR0: begin
          state_q <= ST_HDR1;
`ifndef FRAME_SEQ_EN
          rd_en_q <= (len_q != 16'd0);
`endif
        end

`ifdef FRAME_SEQ_EN
        ST_HDR1: begin
          state_q <= ST_SEQ;
          data_q  <= seq_q;
          rd_en_q <= (len_q != 16'd0);
        end
`endif

        LAST_PRE_ST: begin
          if (len_q == 16'd0) begin
            state_q <= ST_DONE;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b1;
            rd_en_q <= 1'b0;
          end else begin
            state_q   <= ST_PAY;
            pay_sel_q <= 1'b1;
            rem_q     <= len_q;
            rd_en_q   <= (len_q > 16'd1);
          end
        end

        ST_PAY: begin
          if (rem_q == 16'd1) begin
            state_q   <= ST_DONE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            pay_sel_q <= 1'b0;
            done_q    <= 1'b1;
            rd_en_q   <= 1'b0;
          end else begin
            rem_q   <= rem_d;
            // Keep reading while more than one byte remains after this one is issued.
            rd_en_q <= (rem_q > 16'd2);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`ifdef FRAME_SEQ_EN
          seq_q   <= seq_q + 8'd1;
`endif
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: payload bytes bypass the output register; the FIFO already presents them
  // registered one cycle after the read strobe, so another stage would break alignment.
  assign app_tx_data         = pay_sel_q ? pay_data : data_q;
  assign app_tx_data_valid   = valid_q;
  assign app_tx_data_request = req_q;
  assign app_tx_data_length  = length_q;
  assign pay_rd_en           = rd_en_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_frame_header_insert.sv
// Directed self-checking bench for frame_header_insert.
// Covers reset state, normal frames, zero-length payload, length limit and error pulse,
// ignored starts, mid-frame reset abort and (with FRAME_SEQ_EN) sequence wrap.
module tb_frame_header_insert;

`ifdef FRAME_SEQ_EN
  localparam int OVH = 3;
`else
  localparam int OVH = 2;
`endif

  logic        udp_clk;
  logic        rst;
  logic        start;
  logic [15:0] payload_len;
  logic        pay_rd_en;
  logic [7:0]  pay_data;
  logic        udp_tx_ready;
  logic        app_tx_data_request;
  logic        app_tx_ack;
  logic [7:0]  app_tx_data;
  logic        app_tx_data_valid;
  logic [15:0] app_tx_data_length;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk;
  int n_fail;

  // Payload FIFO model storage and control.
  logic [7:0] mem [0:2047];
  int         rd_ptr;
  logic       fifo_clr;

  // Monitor state.
  logic       mon_clr;
  logic [7:0] cap [$];
  int         runs, rd_cnt, done_cnt, err_cnt, req_cnt;
  int         cyc, last_v_cyc, done_cyc;
  logic       prev_valid, prev_req;

  logic [7:0] exp_seq;

  frame_header_insert dut (
    .udp_clk             (udp_clk),
    .rst                 (rst),
    .start               (start),
    .payload_len         (payload_len),
    .pay_rd_en           (pay_rd_en),
    .pay_data            (pay_data),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data         (app_tx_data),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data_length  (app_tx_data_length),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  initial udp_clk = 1'b0;
  always #4 udp_clk = ~udp_clk;

  // FIFO with one cycle of read latency.
  always @(posedge udp_clk) begin
    if (fifo_clr) begin
      rd_ptr <= 0;
    end else if (pay_rd_en) begin
      pay_data <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Monitor: clears on the rising edge, samples DUT outputs on the falling edge.
  always @(udp_clk) begin
    if (udp_clk) begin
      if (mon_clr) begin
        cap.delete();
        runs = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0; req_cnt = 0;
      end
    end else begin
      cyc++;
      if (app_tx_data_valid) begin
        cap.push_back(app_tx_data);
        last_v_cyc = cyc;
        if (!prev_valid) runs++;
      end
      prev_valid = app_tx_data_valid;
      if (pay_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (app_tx_data_request && !prev_req) req_cnt++;
      prev_req = app_tx_data_request;
    end
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle and clear the monitor and FIFO read pointer.
  task automatic start_frame(input logic [15:0] len);
    mon_clr     = 1'b1;
    fifo_clr    = 1'b1;
    start       = 1'b1;
    payload_len = len;
    @(negedge udp_clk);
    mon_clr  = 1'b0;
    fifo_clr = 1'b0;
    start    = 1'b0;
  endtask

  // Pulse start without touching monitor or FIFO.
  task automatic pulse_start(input logic [15:0] len);
    start       = 1'b1;
    payload_len = len;
    @(negedge udp_clk);
    start = 1'b0;
  endtask

  // Wait for request, ack after dly cycles, check first header byte latency.
  task automatic ack_phase(input int len, input int dly);
    int n;
    n = 0;
    while (!app_tx_data_request && n < 50) begin
      @(negedge udp_clk);
      n++;
    end
    check("req_seen", app_tx_data_request, 1);
    check("busy_in_req", busy, 1);
    check("frame_length", app_tx_data_length, len + OVH);
    repeat (dly) @(negedge udp_clk);
    check("req_held", app_tx_data_request, 1);
    check("no_valid_before_ack", app_tx_data_valid, 0);
    app_tx_ack = 1'b1;
    @(negedge udp_clk);
    app_tx_ack = 1'b0;
    check("hdr0_valid_latency", app_tx_data_valid, 1);
    check("hdr0_byte", app_tx_data, 8'h00);
    check("req_dropped", app_tx_data_request, 0);
  endtask

  // Wait for done within budget, check pulse width and return to idle.
  task automatic wait_done(input int len, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge udp_clk);
      n++;
    end
    check("done_seen", done, 1);
    check("length_stable_at_done", app_tx_data_length, len + OVH);
    check("valid_low_at_done", app_tx_data_valid, 0);
    @(negedge udp_clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    @(negedge udp_clk);
  endtask

  // Compare captured frame against header, sequence byte and FIFO contents.
  task automatic check_frame(input int len);
    int mism;
    logic [7:0] e;
    mism = 0;
    check("frame_byte_count", cap.size(), len + OVH);
    for (int i = 0; i < cap.size(); i++) begin
      if (i < 2) begin
        e = 8'h00;
`ifdef FRAME_SEQ_EN
      end else if (i == 2) begin
        e = exp_seq;
`endif
      end else begin
        e = mem[i - OVH];
      end
      if (cap[i] !== e) begin
        if (mism == 0) $display("first differing frame byte at %0d: 0x%0h vs 0x%0h", i, cap[i], e);
        mism++;
      end
    end
    check("frame_content", mism, 0);
    check("valid_contiguous", runs, 1);
    check("rd_en_pulses", rd_cnt, len);
    check("done_pulses", done_cnt, 1);
    check("done_after_last_byte", done_cyc - last_v_cyc, 1);
    exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    payload_len  = '0;
    udp_tx_ready = 1'b1;
    app_tx_ack   = 1'b0;
    mon_clr      = 1'b1;
    fifo_clr     = 1'b1;
    exp_seq      = 8'h00;
    repeat (3) @(negedge udp_clk);

    // Reset state: all outputs low.
    check("rst_valid", app_tx_data_valid, 0);
    check("rst_request", app_tx_data_request, 0);
    check("rst_data", app_tx_data, 0);
    check("rst_length", app_tx_data_length, 0);
    check("rst_rd_en", pay_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst      = 1'b0;
    mon_clr  = 1'b0;
    fifo_clr = 1'b0;
    repeat (2) @(negedge udp_clk);

    // Test 1: len=4, ack 3 cycles after request.
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
    start_frame(16'd4);
    ack_phase(4, 3);
    wait_done(4, 50);
    check_frame(4);

    // Test 2: zero-length payload.
    start_frame(16'd0);
    ack_phase(0, 1);
    wait_done(0, 50);
    check_frame(0);

    // Test 3: one over the limit is rejected, the limit itself is accepted.
    start_frame(16'd1471);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_no_request", app_tx_data_request, 0);
    @(negedge udp_clk);
    check("err_one_cycle", err, 0);
    repeat (10) @(negedge udp_clk);
    check("err_req_count", req_cnt, 0);
    check("err_count", err_cnt, 1);
    check("err_busy_after", busy, 0);
    for (int i = 0; i < 1470; i++) mem[i] = 8'(i) ^ 8'h5A;
    start_frame(16'd1470);
    ack_phase(1470, 2);
    wait_done(1470, 2000);
    check_frame(1470);

    // Test 4: start during PAY and start while stack not ready are both ignored.
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    start_frame(16'd8);
    ack_phase(8, 1);
    repeat (4) @(negedge udp_clk);
    check("busy_mid_frame", busy, 1);
    pulse_start(16'd3);
    wait_done(8, 100);
    check_frame(8);
    udp_tx_ready = 1'b0;
    pulse_start(16'd2);
    repeat (20) @(negedge udp_clk);
    check("ignored_req_count", req_cnt, 1);
    check("ignored_done_count", done_cnt, 1);
    check("ignored_busy", busy, 0);
    check("ignored_request", app_tx_data_request, 0);
    udp_tx_ready = 1'b1;

    // Test 5: reset on the 3rd payload byte aborts the frame immediately.
    for (int i = 0; i < 6; i++) mem[i] = 8'h61 + 8'(i);
    start_frame(16'd6);
    ack_phase(6, 0);
`ifdef FRAME_SEQ_EN
    repeat (5) @(negedge udp_clk);
`else
    repeat (4) @(negedge udp_clk);
`endif
    check("abort_pay3_byte", app_tx_data, 8'h63);
    #1;
    rst = 1'b1;
    #1;
    check("abort_valid", app_tx_data_valid, 0);
    check("abort_data", app_tx_data, 0);
    check("abort_rd_en", pay_rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_request", app_tx_data_request, 0);
    check("abort_length", app_tx_data_length, 0);
    repeat (2) @(negedge udp_clk);
    check("abort_no_done", done_cnt, 0);
    rst     = 1'b0;
    exp_seq = 8'h00;
    @(negedge udp_clk);
    mem[0] = 8'h11; mem[1] = 8'h22;
    start_frame(16'd2);
    ack_phase(2, 2);
    wait_done(2, 50);
    check_frame(2);

`ifdef FRAME_SEQ_EN
    // Test 6: 257 single-byte frames, sequence 00..FF then wraps to 00.
    rst = 1'b1;
    @(negedge udp_clk);
    rst     = 1'b0;
    exp_seq = 8'h00;
    @(negedge udp_clk);
    for (int f = 0; f < 257; f++) begin
      mem[0] = 8'(f) ^ 8'hC3;
      start_frame(16'd1);
      ack_phase(1, 0);
      wait_done(1, 50);
      check_frame(1);
    end
    check("seq_wrapped", exp_seq, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
